// File: rtl/sequenciador_detector_pkg.sv
// Shared types and default sizes for the serial-detector sequencer.
package sequenciador_detector_pkg;

    localparam int LARGURA_PADRAO = 8;
    localparam int CNT_W_PADRAO   = 8;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        LIMPA   = 2'd1,
        DESLOCA = 2'd2,
        ESPERA  = 2'd3
    } estado_t;

endpackage

// File: rtl/sequenciador_detector_if.sv
// Host-side bundle of the sequencer: word handshake, counter clear and per-word results.
interface sequenciador_detector_if
    import sequenciador_detector_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO,
    parameter int CNT_W   = CNT_W_PADRAO
);
    // Handshake: a word moves on a rising edge where valido && pronto; the sender
    // keeps dado/valido stable until that edge, and pronto never waits on valido.
    logic [LARGURA-1:0] dado;
    logic               valido;
    logic               pronto;
    logic               zerar;
    logic               fim;
    logic               detectou;
    logic [CNT_W-1:0]   contagem;

    modport master (
        output dado, valido, zerar,
        input  pronto, fim, detectou, contagem
    );

    modport slave (
        input  dado, valido, zerar,
        output pronto, fim, detectou, contagem
    );

endinterface

// File: rtl/sequenciador_detector.sv
// Serializes host words MSB-first into an external Moore detector, resetting it per word,
// and tallies the detector's responses into a per-word flag and a saturating hit count.
module sequenciador_detector
    import sequenciador_detector_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO,
    parameter int CNT_W   = CNT_W_PADRAO
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sequenciador_detector_if.slave  host,
    output logic                    o_det_rst,
    output logic                    o_det_entrada,
    input  logic                    i_det_saida,
    output estado_t                 o_estado
);

    localparam int BIT_W = $clog2(LARGURA);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    estado_t            r_estado;
    logic [LARGURA-1:0] r_desloc;
    logic [BIT_W-1:0]   r_bits;
    logic               r_amostra;
    logic               r_det_rst;
    logic               r_det_entrada;
    logic               r_fim;
    logic               r_detectou;
    logic [CNT_W-1:0]   r_contagem;

    logic w_pronto;
    logic w_aceita;
    logic w_acerto;

    assign w_pronto = (r_estado == OCIOSO);
    assign w_aceita = host.valido && w_pronto;
    // The detector answers one cycle after each bit, so only that cycle is counted.
    assign w_acerto = r_amostra && i_det_saida;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado      <= OCIOSO;
            r_desloc      <= '0;
            r_bits        <= '0;
            r_amostra     <= 1'b0;
            r_det_rst     <= 1'b1;
            r_det_entrada <= 1'b0;
            r_fim         <= 1'b0;
        end else begin
            r_det_rst     <= 1'b0;
            r_det_entrada <= 1'b0;
            r_fim         <= 1'b0;
            r_amostra     <= (r_estado == DESLOCA);
            case (r_estado)
                OCIOSO: begin
                    if (host.valido) begin
                        r_desloc  <= host.dado;
                        r_bits    <= BIT_W'(LARGURA - 1);
                        r_det_rst <= 1'b1;
                        r_estado  <= LIMPA;
                    end
                end
                LIMPA: begin
                    // First bit is launched here so it is on the wire for the whole first DESLOCA cycle.
                    r_det_entrada <= r_desloc[LARGURA-1];
                    r_desloc      <= {r_desloc[LARGURA-2:0], 1'b0};
                    r_estado      <= DESLOCA;
                end
                DESLOCA: begin
                    if (r_bits == '0) begin
                        r_estado <= ESPERA;
                    end else begin
                        r_det_entrada <= r_desloc[LARGURA-1];
                        r_desloc      <= {r_desloc[LARGURA-2:0], 1'b0};
                        r_bits        <= r_bits - BIT_W'(1);
                    end
                end
                ESPERA: begin
                    r_fim    <= 1'b1;
                    r_estado <= OCIOSO;
                end
                default: r_estado <= OCIOSO;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_detectou <= 1'b0;
            r_contagem <= '0;
        end else begin
            if (w_aceita) begin
                r_detectou <= 1'b0;
            end else if (w_acerto) begin
                r_detectou <= 1'b1;
            end
            // A clear beats a hit landing in the same cycle.
            if (host.zerar) begin
                r_contagem <= '0;
            end else if (w_acerto && (r_contagem != CNT_MAX)) begin
                r_contagem <= r_contagem + CNT_W'(1);
            end
        end
    end

    assign host.pronto   = w_pronto;
    assign host.fim      = r_fim;
    assign host.detectou = r_detectou;
    assign host.contagem = r_contagem;
    assign o_det_rst     = r_det_rst;
    assign o_det_entrada = r_det_entrada;
    assign o_estado      = r_estado;

endmodule

// File: tb/tb_sequenciador_detector.sv
// Bench for sequenciador_detector: two instances (8-bit and 2-bit counters) share stimulus,
// each feeding its own "101" overlapping Moore detector; results are checked on every fim.
module tb_sequenciador_detector;
  import sequenciador_detector_pkg::*;

  logic clk;
  logic rst_n;
  logic [7:0] tb_dado;
  logic tb_valido;
  logic tb_zerar;

  sequenciador_detector_if #(.LARGURA(8), .CNT_W(8)) if8 ();
  sequenciador_detector_if #(.LARGURA(8), .CNT_W(2)) if2 ();

  assign if8.dado = tb_dado;
  assign if8.valido = tb_valido;
  assign if8.zerar = tb_zerar;
  assign if2.dado = tb_dado;
  assign if2.valido = tb_valido;
  assign if2.zerar = tb_zerar;

  logic det_rst8, det_ent8, det_sai8;
  logic det_rst2, det_ent2, det_sai2;
  estado_t estado8, estado2;
  logic [1:0] det8_q, det2_q;

  sequenciador_detector #(.LARGURA(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .host(if8.slave),
    .o_det_rst(det_rst8), .o_det_entrada(det_ent8), .i_det_saida(det_sai8),
    .o_estado(estado8)
  );

  sequenciador_detector #(.LARGURA(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .host(if2.slave),
    .o_det_rst(det_rst2), .o_det_entrada(det_ent2), .i_det_saida(det_sai2),
    .o_estado(estado2)
  );

  // External detector: states 0=idle, 1=seen 1, 2=seen 10, 3=seen 101 (output high).
  function automatic logic [1:0] det_prox(input logic [1:0] s, input logic b);
    case (s)
      2'd0: det_prox = b ? 2'd1 : 2'd0;
      2'd1: det_prox = b ? 2'd1 : 2'd2;
      2'd2: det_prox = b ? 2'd3 : 2'd0;
      default: det_prox = b ? 2'd1 : 2'd2;
    endcase
  endfunction

  always @(posedge clk or posedge det_rst8)
    if (det_rst8) det8_q <= 2'd0; else det8_q <= det_prox(det8_q, det_ent8);
  always @(posedge clk or posedge det_rst2)
    if (det_rst2) det2_q <= 2'd0; else det2_q <= det_prox(det2_q, det_ent2);
  assign det_sai8 = (det8_q == 2'd3);
  assign det_sai2 = (det2_q == 2'd3);

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // checking
  int total = 0;
  int passou = 0;

  task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    total++;
    if (obs === esp) passou++;
    else $display("FAIL %s: observed=%0h expected=%0h", tag, obs, esp);
  endtask

  // scoreboard: {detectou, contagem}
  logic [8:0] exp_q[$];
  logic [2:0] exp2_q[$];
  int m8 = 0;
  int m2 = 0;

  task automatic modelo_empurra(input logic [7:0] d, input int zc);
    logic det;
    logic hit;
    int k;
    det = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      hit = 1'b0;
      if (c >= 5) begin
        k = c - 3;
        hit = d[9 - k] && !d[8 - k] && d[7 - k];
      end
      if (c == zc) begin
        m8 = 0;
        m2 = 0;
      end else if (hit) begin
        if (m8 < 255) m8++;
        if (m2 < 3) m2++;
      end
      if (hit) det = 1'b1;
    end
    exp_q.push_back({det, 8'(m8)});
    exp2_q.push_back({det, 2'(m2)});
  endtask

  always @(negedge clk) begin
    logic [8:0] e8;
    logic [2:0] e2;
    if (rst_n) begin
      if (if8.fim) begin
        verificar("fila8_nao_vazia", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e8 = exp_q.pop_front();
          verificar("detectou8", if8.detectou, e8[8]);
          verificar("contagem8", if8.contagem, e8[7:0]);
          verificar("pronto_no_fim8", if8.pronto, 1);
        end
      end
      if (if2.fim) begin
        verificar("fila2_nao_vazia", (exp2_q.size() > 0), 1);
        if (exp2_q.size() > 0) begin
          e2 = exp2_q.pop_front();
          verificar("detectou2", if2.detectou, e2[2]);
          verificar("contagem2", if2.contagem, e2[1:0]);
        end
      end
    end
  end

  // drivers
  task automatic esperar_pronto(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!if8.pronto && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!if8.pronto) verificar(tag, if8.pronto, 1);
  endtask

  task automatic enviar(input logic [7:0] d, input int zc,
                        output logic [7:0] serial, output int ciclo_fim, output logic rst_c1);
    serial = '0;
    ciclo_fim = -1;
    rst_c1 = 1'b0;
    @(posedge clk); #1;
    tb_dado = d;
    tb_valido = 1'b1;
    esperar_pronto("aceite_timeout");
    modelo_empurra(d, zc);
    @(posedge clk); #1;
    tb_valido = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tb_zerar = (c == zc);
      @(negedge clk);
      if (c == 1) rst_c1 = det_rst8;
      if (c >= 2 && c <= 9) serial[9 - c] = det_ent8;
      if (if8.fim) begin
        ciclo_fim = c;
        break;
      end
      @(posedge clk); #1;
    end
    tb_zerar = 1'b0;
  endtask

  task automatic checar_reset(input string tag);
    verificar({tag, "_pronto"}, if8.pronto, 1);
    verificar({tag, "_det_rst"}, det_rst8, 1);
    verificar({tag, "_det_entrada"}, det_ent8, 0);
    verificar({tag, "_fim"}, if8.fim, 0);
    verificar({tag, "_detectou"}, if8.detectou, 0);
    verificar({tag, "_contagem"}, if8.contagem, 0);
    verificar({tag, "_estado"}, 32'(estado8), 32'(OCIOSO));
  endtask

  logic [7:0] serial;
  int ciclo_fim;
  logic rst_c1;
  int n;

  initial begin
    rst_n = 1'b0;
    tb_dado = '0;
    tb_valido = 1'b0;
    tb_zerar = 1'b0;
    repeat (3) @(negedge clk);
    checar_reset("reset");
    rst_n = 1'b1;
    #1;
    verificar("det_rst_antes_borda", det_rst8, 1);
    @(posedge clk); #1;
    verificar("det_rst_apos_borda", det_rst8, 0);

    // single hit
    enviar(8'hA0, 0, serial, ciclo_fim, rst_c1);
    verificar("a0_serial", serial, 8'hA0);
    verificar("a0_ciclo_fim", ciclo_fim, 11);
    verificar("a0_det_rst_limpa", rst_c1, 1);
    verificar("a0_contagem", if8.contagem, 1);

    // repeated hits and no-hit words
    enviar(8'hAA, 0, serial, ciclo_fim, rst_c1);
    verificar("aa_serial", serial, 8'hAA);
    verificar("aa_contagem", if8.contagem, 4);
    enviar(8'hFF, 0, serial, ciclo_fim, rst_c1);
    verificar("ff_detectou", if8.detectou, 0);
    enviar(8'h00, 0, serial, ciclo_fim, rst_c1);
    verificar("00_contagem", if8.contagem, 4);

    for (int i = 0; i < 6; i++) begin
      enviar(8'($urandom_range(0, 255)), 0, serial, ciclo_fim, rst_c1);
      verificar("aleat_ciclo_fim", ciclo_fim, 11);
    end

    // zerar while idle, then zerar colliding with a sampled hit
    @(posedge clk); #1;
    tb_zerar = 1'b1;
    @(posedge clk); #1;
    tb_zerar = 1'b0;
    m8 = 0;
    m2 = 0;
    verificar("zerar_ocioso", if8.contagem, 0);
    enviar(8'hA0, 5, serial, ciclo_fim, rst_c1);
    verificar("zerar_com_acerto_contagem", if8.contagem, 0);
    verificar("zerar_com_acerto_detectou", if8.detectou, 1);

    // back-to-back with valido held, garbage on dado while busy
    @(posedge clk); #1;
    tb_dado = 8'hA0;
    tb_valido = 1'b1;
    esperar_pronto("b2b_aceite_timeout");
    modelo_empurra(8'hA0, 0);
    @(posedge clk); #1;
    for (int c = 1; c <= 10; c++) begin
      tb_dado = (c == 10) ? 8'hAA : 8'($urandom_range(0, 255));
      if (c == 5) begin
        @(negedge clk);
        verificar("b2b_ocupado_pronto", if8.pronto, 0);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    verificar("b2b_fim", if8.fim, 1);
    verificar("b2b_pronto_no_fim", if8.pronto, 1);
    modelo_empurra(8'hAA, 0);
    @(posedge clk); #1;
    tb_valido = 1'b0;
    verificar("b2b_segundo_aceite", 32'(estado8), 32'(LIMPA));
    n = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (if8.fim) begin
        n = j;
        break;
      end
    end
    verificar("b2b_ciclo_fim2", n, 11);

    // reset in the middle of a word
    @(posedge clk); #1;
    tb_dado = 8'hAA;
    tb_valido = 1'b1;
    esperar_pronto("rst_meio_aceite_timeout");
    @(posedge clk); #1;
    tb_valido = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checar_reset("rst_meio");
    exp_q.delete();
    exp2_q.delete();
    m8 = 0;
    m2 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    enviar(8'hA0, 0, serial, ciclo_fim, rst_c1);
    verificar("pos_rst_contagem", if8.contagem, 1);

    // saturation of the narrow counter
    for (int i = 0; i < 4; i++) enviar(8'hAA, 0, serial, ciclo_fim, rst_c1);
    verificar("sat2_contagem", if2.contagem, 3);
    verificar("sat_largo_contagem", if8.contagem, 13);

    @(negedge clk);
    verificar("fila8_restante", exp_q.size(), 0);
    verificar("fila2_restante", exp2_q.size(), 0);
    $display("%0d/%0d checks passed", passou, total);
    $finish;
  end

endmodule

// File: doc/sequenciador_detector.md
# sequenciador_detector

- Controller that sequences the serial sequence-detector FSM (single input bit, single Moore output bit, active-high async reset).
- Accepts LARGURA-bit words over a valid/ready handshake and resets the detector before each word.
- Shifts the word MSB-first into the detector, one bit per clock, and samples the detector output for every bit.
- Reports a per-word detection flag and a saturating total hit count to the host logic.

## Interface
- LARGURA, 8, word width in bits; must be ≥ 2
- CNT_W, 8, hit-counter width
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- dado  in  LARGURA  word to serialize; sent MSB first
- valido  in  1  dado valid; sender holds dado/valido until accepted
- pronto  out  1  controller idle, can accept a word
- zerar  in  1  synchronous clear of contagem, level-sensitive
- det_rst  out  1  active-high reset to detector
- det_entrada  out  1  serial bit to detector
- det_saida  in  1  detector Moore output
- fim  out  1  one-cycle pulse: word finished, results valid
- detectou  out  1  at least one hit in last word; held until next accept
- contagem  out  CNT_W  total hits since reset/zerar; saturates at 2^CNT_W−1

## Operation
- States: OCIOSO, LIMPA, DESLOCA, ESPERA.
- OCIOSO:
  - pronto=1.
  - Accept on valido&&pronto: load shift register with dado, load bit counter with LARGURA−1, clear detectou, go to LIMPA.
- LIMPA: one cycle, det_rst=1 (detector forced to its initial state), then DESLOCA.
- DESLOCA:
  - det_entrada = shift register MSB.
  - Each cycle: shift left, decrement bit counter.
  - At counter 0 go to ESPERA.
  - Exactly LARGURA cycles.
- ESPERA: one cycle, samples the detector response to the last bit, then OCIOSO.
- Sampling: det_saida is counted only in the cycle after a DESLOCA cycle. This gives LARGURA samples per word. det_saida in all other cycles is ignored.
- Sampled hit: contagem += 1 (holds at max), detectou ← 1.
- zerar: contagem ← 0 at next edge, in any state. zerar wins over a simultaneous hit; detectou is unaffected.
- Outside DESLOCA, det_entrada=0. Outside LIMPA, det_rst=0.
- Detector state does not carry across words; patterns spanning a word boundary are never counted.
- valido while pronto=0 is ignored; no word is dropped while the sender holds valido.

## Timing
- Reset values (while rst_n low):
  - Controller state OCIOSO.
  - pronto=1, det_rst=1, det_entrada=0, fim=0, detectou=0, contagem=0.
  - Shift register and bit counter 0.
- det_rst deasserts at the first clk edge after rst_n release.
- Word accepted in cycle 0:
  - LIMPA in cycle 1.
  - det_entrada carries bit LARGURA−1−k in cycle 2+k, for k=0..LARGURA−1.
  - ESPERA in cycle LARGURA+2.
  - Cycle LARGURA+3: pronto=1, fim=1, contagem and detectou final.
- Accept-to-accept minimum is LARGURA+3 cycles. A new accept is allowed in the fim cycle.
- det_rst, det_entrada, fim, detectou and contagem are registered outputs, glitch-free. pronto decodes state.
- rst_n asserted mid-word aborts immediately. The partial word is discarded; the hits it already counted remain lost on reset, because contagem resets to 0.

## Structure
- Shared package: state encoding (2-bit, OCIOSO=0, LIMPA=1, DESLOCA=2, ESPERA=3) and the default LARGURA/CNT_W constants.
- Bit counter width is $clog2(LARGURA).
- Single module; the detector is instantiated at the level above, not inside.
- No sub-module needed. If one is wanted, split out contador_saturado (CNT_W, inc, clr).

## Test plan
- Reset check: hold rst_n low, then release → pronto=1, det_rst=1 during reset and 0 one edge later, contagem=0, fim=0.
- Single hit: dado=8'hA0 → det_entrada 1,0,1,0,0,0,0,0 in cycles 2–9, fim in cycle 11, detectou=1, contagem=1.
- Repeated hits: dado=8'hAA → fim with contagem +3, detectou=1. Next word 8'hFF → contagem unchanged, detectou=0. Next word 8'h00 → contagem unchanged.
- Back-to-back and hold: valido held continuously with two words → second accept exactly in the first word's fim cycle. dado changes while pronto=0 have no effect.
- zerar and saturation: zerar asserted in the same cycle a hit is sampled → contagem=0. With CNT_W=2, four 8'hAA words → contagem=3.
- Reset mid-word: rst_n low in cycle 5 of a word → all reset values immediately. After release, a fresh 8'hA0 gives contagem=1.
